button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end stage for the dice / traffic-light block. Takes the raw push-button from the board pin, synchronises and debounces it, and drives the `button` input of `dice_or_light` with a clean level. A long press toggles `sel` so one physical button selects both throw and mode. It also emits single-cycle press and long-press strobes for status LEDs and benches.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count, ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive agreeing cycles needed to accept a level change, ≥1.
- `LONG_PRESS_CYCLES`, default 200: cycles of debounced high needed to toggle `sel`, ≥2.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset `rst`, synchronous, active-high.
- `btn_raw` in 1: asynchronous, bouncy button pin, active-high.
- `button` out 1: debounced level, to `dice_or_light.button`.
- `sel` out 1: mode select, to `dice_or_light.sel`; 0 = dice, 1 = traffic lights.
- `press_pulse` out 1: one-cycle strobe on debounced rising edge.
- `long_pulse` out 1: one-cycle strobe when `sel` toggles.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops in series, reset to 0; its output is `btn_s`.
- **Debouncer:**
  - A counter increments each cycle that `btn_s` differs from the stable level; it clears to 0 on any cycle they agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
  - The counter width is `$clog2(DEBOUNCE_CYCLES+1)` and it never wraps.
- **FSM states:** IDLE, PRESSED, LONG. Encoding is localparams from the shared header.
  - IDLE: on debounced rise go to PRESSED, assert `press_pulse`, clear the hold counter.
  - PRESSED: the hold counter increments each cycle. When it reaches `LONG_PRESS_CYCLES`, go to LONG, invert `sel`, assert `long_pulse`.
  - LONG: the hold counter is frozen. There is no further toggle however long the button is held.
  - PRESSED or LONG: on debounced fall go to IDLE and clear the hold counter.
  - Simultaneous fall and threshold in the same cycle: the fall wins. Go to IDLE and leave `sel` unchanged.
- **Outputs:**
  - `button` equals the stable level, registered.
  - `press_pulse`, `long_pulse` and `sel` are registered with no combinational path from `btn_raw`.
  - `sel` is held across IDLE and only changes via `long_pulse` or reset.
- **Reset:**
  - All state clears: sync flops, counters, state = IDLE, `button` = `sel` = `press_pulse` = `long_pulse` = 0.
  - Reset mid-press or in LONG drops `sel` to 0 and `button` to 0 the next edge.
  - A button still held after reset release counts as a new press after full latency.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples `btn_raw` at a new, thereafter steady, value.
- `button` changes on edge `SYNC_STAGES + DEBOUNCE_CYCLES`. With defaults that is edge 18.
- `press_pulse` is high the same cycle `button` first reads 1, and for exactly 1 cycle.
- If `button` rose at edge E and stays high, `sel` toggles and `long_pulse` is high at edge E + `LONG_PRESS_CYCLES`.
- Bounce shorter than `DEBOUNCE_CYCLES` consecutive cycles produces no output change.
- Throughput: one press is recognised per debounced rise; there is no queueing.

## Structure
- **Shared header/package `button_pkg`:** FSM state localparams (IDLE = 2'd0, PRESSED = 2'd1, LONG = 2'd2) and a `SEL_DICE`/`SEL_LIGHTS` constant pair shared with `dice_or_light`.
- **Sub-module `sync_debounce`:** synchroniser plus debouncer, parameters `SYNC_STAGES` and `DEBOUNCE_CYCLES`, output is the stable level. `button_conditioner` instantiates it and holds the FSM.

## Test plan
All scenarios use `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20.
- **Reset with button held:** `rst`=1 for 3 cycles with `btn_raw`=1 → all outputs 0 during reset; after release `button` rises on edge 6 with one `press_pulse`.
- **Clean press:** `btn_raw` 0→1 held 10 cycles, then 0 → `button` high on edge 6, `press_pulse` high exactly 1 cycle, `sel` stays 0; `button` low 6 edges after release.
- **Bounce:** `btn_raw` toggles every 2 cycles for 12 cycles, then steady 1 → no `button` change during bounce; single `press_pulse` at 6 edges into the steady 1.
- **Long press twice:** hold 30 cycles → `sel` 0→1 exactly 20 cycles after `button` rise, one `long_pulse`; second 30-cycle hold → `sel` 1→0.
- **Release at threshold:** debounced fall lands on edge E+20 → FSM goes to IDLE, `sel` unchanged, no `long_pulse`.
- **Reset in LONG:** `sel`=1 with button held, `rst` for 1 cycle → `sel`=0, `button`=0 next edge; then `button` re-rises 6 edges after `rst` drops.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: FSM state encoding and sel constants shared with dice_or_light
package button_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;
    localparam logic SEL_DICE   = 1'b0;
    localparam logic SEL_LIGHTS = 1'b1;
endpackage

// File: rtl/button_conditioner_sync_debounce.sv
// sync_debounce: multi-flop synchroniser followed by a saturating-agreement debouncer
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic flip
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic btn_s;
    assign btn_s = sync[SYNC_STAGES-1];
    // flip is high in the cycle before level changes, so the FSM can strobe in step with it
    assign flip = (btn_s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], btn_raw};
            cnt   <= (btn_s == level || flip) ? '0 : cnt + 1'b1;
            level <= flip ? btn_s : level;
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced button level, press strobe and long-press sel toggle
module button_conditioner
    import button_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic button,
    output logic sel,
    output logic press_pulse,
    output logic long_pulse
);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    logic level, flip;
    state_t state, state_n;
    logic [HW-1:0] hold, hold_n;
    logic sel_n, press_n, long_n;
    sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .level  (level),
        .flip   (flip)
    );
    assign button = level;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold        <= '0;
            sel         <= SEL_DICE;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= state_n;
            hold        <= hold_n;
            sel         <= sel_n;
            press_pulse <= press_n;
            long_pulse  <= long_n;
        end
    end
    // outside IDLE a flip can only be the debounced fall, which beats the threshold
    always_comb begin
        state_n = state;
        hold_n  = hold;
        sel_n   = sel;
        press_n = 1'b0;
        long_n  = 1'b0;
        case (state)
            IDLE: if (flip && !level) begin
                state_n = PRESSED;
                hold_n  = '0;
                press_n = 1'b1;
            end
            PRESSED: if (flip) begin
                state_n = IDLE;
                hold_n  = '0;
            end else begin
                hold_n = hold + 1'b1;
                if (hold == HW'(LONG_PRESS_CYCLES - 1)) begin
                    state_n = LONG;
                    sel_n   = ~sel;
                    long_n  = 1'b1;
                end
            end
            LONG: if (flip) begin
                state_n = IDLE;
                hold_n  = '0;
            end
            default: begin
                state_n = IDLE;
                hold_n  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed vectors and multi-cycle sequences for button_conditioner
module tb_button_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic button, sel, press_pulse, long_pulse;
    int n_cmp = 0;
    int n_err = 0;
    int t_rise, t_fall, n_press, t_press, n_long, t_long;

    typedef struct {
        logic       r;
        logic       b;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[20];

    button_conditioner #(
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .button     (button),
        .sel        (sel),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic b);
        rst = r;
        btn_raw = b;
        @(posedge clk);
        #1;
    endtask

    // nb bounce ticks (1,1,0,0,...), then hi ticks high, then lo ticks low; records event ticks
    task automatic run_seq(input int nb, input int hi, input int lo);
        logic prev_b;
        prev_b = button;
        t_rise = 0; t_fall = 0; n_press = 0; t_press = 0; n_long = 0; t_long = 0;
        for (int t = 1; t <= nb + hi + lo; t++) begin
            tick(1'b0, (t <= nb) ? (((t - 1) / 2) % 2 == 0) : (t <= nb + hi));
            if (button && !prev_b && t_rise == 0) t_rise = t;
            if (!button && prev_b && t_fall == 0) t_fall = t;
            if (press_pulse) begin n_press++; if (t_press == 0) t_press = t; end
            if (long_pulse) begin n_long++; if (t_long == 0) t_long = t; end
            prev_b = button;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, 4'b0000};
        for (int i = 3; i < 8; i++) vecs[i] = '{1'b0, 1'b1, 4'b0000};
        vecs[8] = '{1'b0, 1'b1, 4'b1010};
        for (int i = 9; i < 13; i++) vecs[i] = '{1'b0, 1'b1, 4'b1000};
        for (int i = 13; i < 18; i++) vecs[i] = '{1'b0, 1'b0, 4'b1000};
        for (int i = 18; i < 20; i++) vecs[i] = '{1'b0, 1'b0, 4'b0000};
        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].r, vecs[i].b);
            check($sformatf("vec%0d", i), {button, sel, press_pulse, long_pulse}, vecs[i].exp);
        end

        run_seq(0, 30, 8);
        check("long1_rise", t_rise, 6);
        check("long1_press_n", n_press, 1);
        check("long1_press_t", t_press, 6);
        check("long1_long_n", n_long, 1);
        check("long1_long_t", t_long, 26);
        check("long1_fall", t_fall, 36);
        check("long1_sel", sel, 1);

        run_seq(0, 20, 8);
        check("thr_fall", t_fall, 26);
        check("thr_long_n", n_long, 0);
        check("thr_sel", sel, 1);

        run_seq(0, 30, 8);
        check("long2_long_n", n_long, 1);
        check("long2_long_t", t_long, 26);
        check("long2_sel", sel, 0);

        run_seq(0, 21, 8);
        check("thr1_fall", t_fall, 27);
        check("thr1_long_t", t_long, 26);
        check("thr1_sel", sel, 1);

        run_seq(12, 10, 8);
        check("bounce_rise", t_rise, 18);
        check("bounce_press_n", n_press, 1);
        check("bounce_press_t", t_press, 18);
        check("bounce_fall", t_fall, 28);
        check("bounce_sel", sel, 1);

        run_seq(0, 21, 8);
        check("thr2_sel", sel, 0);

        for (int t = 0; t < 30; t++) tick(1'b0, 1'b1);
        check("inlong_btn_sel", {button, sel}, 2'b11);
        tick(1'b1, 1'b1);
        check("rst_long_outs", {button, sel, press_pulse, long_pulse}, 4'b0000);
        run_seq(0, 10, 8);
        check("rerise_t", t_rise, 6);
        check("rerise_press_n", n_press, 1);
        check("rerise_long_n", n_long, 0);
        check("rerise_sel", sel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
